// File: rtl/ibex_lsu_split.sv
// rtl/ibex_lsu_split.sv - load/store unit with word-crossing split, data alignment and extension
module ibex_lsu_split #(
    parameter bit MisalignedEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_valid_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        lsu_busy_o
);

    typedef enum logic [2:0] {IDLE, WAIT_GNT_1, WAIT_RV_1, WAIT_GNT_2, WAIT_RV_2} state_e;

    // Byte enables of the first (or only) bus transaction; type 11 falls into the word case.
    function automatic logic [3:0] be_first(input logic [1:0] ty, input logic [1:0] off);
        logic [3:0] be;
        case (ty)
            2'b10:   be = 4'b0001 << off;
            2'b01: begin
                case (off)
                    2'd0:    be = 4'b0011;
                    2'd1:    be = 4'b0110;
                    2'd2:    be = 4'b1100;
                    default: be = 4'b1000;
                endcase
            end
            default: be = 4'b1111 << off;
        endcase
        return be;
    endfunction

    // Byte enables of the second transaction of a split access.
    function automatic logic [3:0] be_second(input logic [1:0] ty, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        if (ty == 2'b01) begin
            be = 4'b0001;
        end else if (ty != 2'b10) begin
            case (off)
                2'd1:    be = 4'b0001;
                2'd2:    be = 4'b0011;
                2'd3:    be = 4'b0111;
                default: be = 4'b0000;
            endcase
        end
        return be;
    endfunction

    function automatic logic is_split(input logic [1:0] ty, input logic [1:0] off);
        logic s;
        case (ty)
            2'b01:   s = (off == 2'd3);
            2'b10:   s = 1'b0;
            default: s = (off != 2'd0);
        endcase
        return s;
    endfunction

    state_e      state;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [1:0]  type_q;
    logic        sign_q;
    logic [1:0]  off_q;
    logic [31:0] rdata1_q;
    logic        err_pend_q;

    logic [1:0]  in_off;
    logic        in_split;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        accept;
    logic        issue_idle;
    logic [31:0] addr_next;
    logic [3:0]  be_next;
    logic        split_q;
    logic        rv1_err;
    logic        rv2;
    logic        resp_err;
    logic [31:0] r_word;
    logic [31:0] r_ext;

    assign in_off     = adder_result_ex_i[1:0];
    assign in_split   = is_split(lsu_type_i, in_off);
    assign in_be      = be_first(lsu_type_i, in_off);
    assign in_wdata   = 32'({lsu_wdata_i, lsu_wdata_i} >> (6'd32 - {1'b0, in_off, 3'b000}));
    assign accept     = (state == IDLE) && !err_pend_q && lsu_req_i;
    assign issue_idle = accept && (MisalignedEn || !in_split);
    assign addr_next  = addr_q + 32'd4;
    assign be_next    = be_second(type_q, off_q);
    assign split_q    = is_split(type_q, off_q);

    // Bus outputs: straight from the inputs in IDLE, from the captured registers otherwise.
    always_comb begin
        data_req_o   = 1'b0;
        data_addr_o  = 32'd0;
        data_be_o    = 4'd0;
        data_we_o    = 1'b0;
        data_wdata_o = 32'd0;
        case (state)
            IDLE: begin
                if (issue_idle) begin
                    data_req_o   = 1'b1;
                    data_addr_o  = {adder_result_ex_i[31:2], 2'b00};
                    data_be_o    = in_be;
                    data_we_o    = lsu_we_i;
                    data_wdata_o = in_wdata;
                end
            end
            WAIT_RV_1: begin
                data_req_o   = data_rvalid_i && !data_err_i;
                data_addr_o  = addr_next;
                data_be_o    = be_next;
                data_we_o    = we_q;
                data_wdata_o = wdata_q;
            end
            default: begin
                data_req_o   = (state == WAIT_GNT_1) || (state == WAIT_GNT_2);
                data_addr_o  = addr_q;
                data_be_o    = be_q;
                data_we_o    = we_q;
                data_wdata_o = wdata_q;
            end
        endcase
    end

    // Response path: completion, error qualification and load data alignment/extension.
    always_comb begin
        rv1_err  = (state == WAIT_RV_1) && data_rvalid_i && data_err_i;
        rv2      = (state == WAIT_RV_2) && data_rvalid_i;
        resp_err = err_pend_q || rv1_err || (rv2 && data_err_i);
        r_word   = 32'({(split_q ? data_rdata_i : 32'd0), (split_q ? rdata1_q : data_rdata_i)}
                       >> {off_q, 3'b000});
        case (type_q)
            2'b10:   r_ext = {{24{sign_q & r_word[7]}}, r_word[7:0]};
            2'b01:   r_ext = {{16{sign_q & r_word[15]}}, r_word[15:0]};
            default: r_ext = r_word;
        endcase
        lsu_resp_valid_o = err_pend_q || rv1_err || rv2;
        load_err_o       = resp_err && !we_q;
        store_err_o      = resp_err && we_q;
        lsu_rdata_o      = (rv2 && !data_err_i && !we_q) ? r_ext : 32'd0;
        lsu_busy_o       = (state != IDLE) || err_pend_q;
    end

    // Access sequencing: capture on acceptance, walk through one or two bus transactions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            type_q     <= 2'd0;
            sign_q     <= 1'b0;
            off_q      <= 2'd0;
            rdata1_q   <= 32'd0;
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= {adder_result_ex_i[31:2], 2'b00};
                        be_q    <= in_be;
                        wdata_q <= in_wdata;
                        we_q    <= lsu_we_i;
                        type_q  <= lsu_type_i;
                        sign_q  <= lsu_sign_ext_i;
                        off_q   <= in_off;
                        if (!issue_idle) begin
                            err_pend_q <= 1'b1;
                        end else if (in_split) begin
                            state <= data_gnt_i ? WAIT_RV_1 : WAIT_GNT_1;
                        end else begin
                            state <= data_gnt_i ? WAIT_RV_2 : WAIT_GNT_2;
                        end
                    end
                end
                WAIT_GNT_1: if (data_gnt_i) state <= WAIT_RV_1;
                WAIT_RV_1: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            state <= IDLE;
                        end else begin
                            rdata1_q <= data_rdata_i;
                            addr_q   <= addr_next;
                            be_q     <= be_next;
                            state    <= data_gnt_i ? WAIT_RV_2 : WAIT_GNT_2;
                        end
                    end
                end
                WAIT_GNT_2: if (data_gnt_i) state <= WAIT_RV_2;
                WAIT_RV_2:  if (data_rvalid_i) state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_lsu_split.sv
// tb/tb_ibex_lsu_split.sv - scoreboard bench for ibex_lsu_split
module tb_ibex_lsu_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        lsu_req, lsu_req0, lsu_we, lsu_sign_ext;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_wdata, adder_result;
    logic        data_req, data_gnt, data_rvalid, data_err, data_we;
    logic [31:0] data_addr, data_wdata, data_rdata, lsu_rdata;
    logic [3:0]  data_be;
    logic        resp_valid, load_err, store_err, busy;

    logic        data_req0, data_we0, resp_valid0, load_err0, store_err0, busy0;
    logic [31:0] data_addr0, data_wdata0, lsu_rdata0;
    logic [3:0]  data_be0;
    logic        gnt0 = 1'b0;
    logic        rvalid0 = 1'b0;
    logic        err0 = 1'b0;
    logic [31:0] rdata0 = 32'd0;

    ibex_lsu_split #(.MisalignedEn(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .lsu_req_i(lsu_req), .lsu_we_i(lsu_we),
        .lsu_type_i(lsu_type), .lsu_sign_ext_i(lsu_sign_ext), .lsu_wdata_i(lsu_wdata),
        .adder_result_ex_i(adder_result), .data_req_o(data_req), .data_gnt_i(data_gnt),
        .data_rvalid_i(data_rvalid), .data_err_i(data_err), .data_addr_o(data_addr),
        .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_rdata_i(data_rdata), .lsu_rdata_o(lsu_rdata), .lsu_resp_valid_o(resp_valid),
        .load_err_o(load_err), .store_err_o(store_err), .lsu_busy_o(busy)
    );

    ibex_lsu_split #(.MisalignedEn(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .lsu_req_i(lsu_req0), .lsu_we_i(lsu_we),
        .lsu_type_i(lsu_type), .lsu_sign_ext_i(lsu_sign_ext), .lsu_wdata_i(lsu_wdata),
        .adder_result_ex_i(adder_result), .data_req_o(data_req0), .data_gnt_i(gnt0),
        .data_rvalid_i(rvalid0), .data_err_i(err0), .data_addr_o(data_addr0),
        .data_we_o(data_we0), .data_be_o(data_be0), .data_wdata_o(data_wdata0),
        .data_rdata_i(rdata0), .lsu_rdata_o(lsu_rdata0), .lsu_resp_valid_o(resp_valid0),
        .load_err_o(load_err0), .store_err_o(store_err0), .lsu_busy_o(busy0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        le;
        logic        se;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    exp_t sb[$];
    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int gnt_wait = 0;
    bit stale = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus responder: grants after gnt_wait cycles, returns queued responses one cycle later,
    // and checks every requested transaction (including stability while waiting for grant).
    initial begin
        bit pending = 1'b0;
        int wcnt = 0;
        bus_t b;
        rsp_t r;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; data_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            data_gnt = 1'b0;
            if (!rst_n) begin
                pending = 1'b0; wcnt = 0; rsp_q.delete();
                data_rvalid = 1'b0; data_err = 1'b0; data_rdata = 32'd0;
            end else begin
                if (stale) begin
                    data_rvalid = 1'b1; data_err = 1'b0; data_rdata = 32'h1234_5678; stale = 1'b0;
                end else if (pending) begin
                    pending = 1'b0;
                    if (rsp_q.size() == 0) begin
                        check("rsp_queue_nonempty", 64'(0), 64'(1));
                        data_rvalid = 1'b0;
                    end else begin
                        r = rsp_q.pop_front();
                        data_rvalid = 1'b1; data_err = r.err; data_rdata = r.rdata;
                    end
                end else begin
                    data_rvalid = 1'b0; data_err = 1'b0; data_rdata = 32'd0;
                end
                #1;
                if (data_req) begin
                    if (bus_q.size() == 0) begin
                        check("bus_unexpected_req", 64'(data_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        b = bus_q[0];
                        check("bus_addr_be_we", 64'({data_addr, data_be, data_we}),
                              64'({b.addr, b.be, b.we}));
                        check("bus_wdata", 64'(data_wdata), 64'(b.wdata));
                        if (wcnt < gnt_wait) begin
                            wcnt++;
                        end else begin
                            wcnt = 0;
                            data_gnt = 1'b1;
                            pending = 1'b1;
                            void'(bus_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT completes an access.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'({lsu_rdata, load_err, store_err}), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("resp_data_err", 64'({lsu_rdata, load_err, store_err}),
                      64'({e.rdata, e.le, e.se}));
                if (e.cyc >= 0) check("resp_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we,
                            input logic [31:0] wd);
        bus_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    task automatic push_rsp(input logic err, input logic [31:0] rd);
        rsp_t r;
        r.err = err; r.rdata = rd;
        rsp_q.push_back(r);
    endtask

    // Returns at posedge+1 of the first cycle with busy low.
    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic issue(input logic we, input logic [1:0] ty, input logic sx,
                         input logic [31:0] wd, input logic [31:0] ad,
                         input logic [31:0] erd, input logic ele, input logic ese,
                         input int lat, input int gw);
        exp_t e;
        wait_idle();
        gnt_wait = gw;
        e.rdata = erd; e.le = ele; e.se = ese;
        e.cyc = (lat < 0) ? -1 : cyc + lat;
        sb.push_back(e);
        lsu_we = we; lsu_type = ty; lsu_sign_ext = sx; lsu_wdata = wd; adder_result = ad;
        lsu_req = 1'b1;
        @(posedge clk); #1;
        lsu_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        lsu_req = 1'b0; lsu_req0 = 1'b0; lsu_we = 1'b0; lsu_type = 2'b00;
        lsu_sign_ext = 1'b0; lsu_wdata = 32'd0; adder_result = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus", 64'({data_req, data_we, data_be, data_addr}), 64'(0));
        check("reset_wdata", 64'(data_wdata), 64'(0));
        check("reset_rsp", 64'({lsu_rdata, resp_valid, load_err, store_err, busy}), 64'(0));
        rst_n = 1'b1;

        // aligned word load, zero wait
        push_bus(32'h100, 4'b1111, 1'b0, 32'd0); push_rsp(1'b0, 32'hDEAD_BEEF);
        issue(1'b0, 2'b00, 1'b0, 32'd0, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 0);
        // byte load at offset 3, signed then unsigned
        push_bus(32'h100, 4'b1000, 1'b0, 32'd0); push_rsp(1'b0, 32'h8012_3456);
        issue(1'b0, 2'b10, 1'b1, 32'd0, 32'h103, 32'hFFFF_FF80, 1'b0, 1'b0, 1, 0);
        push_bus(32'h100, 4'b1000, 1'b0, 32'd0); push_rsp(1'b0, 32'h8012_3456);
        issue(1'b0, 2'b10, 1'b0, 32'd0, 32'h103, 32'h0000_0080, 1'b0, 1'b0, 1, 0);
        // split word store
        push_bus(32'h200, 4'b1100, 1'b1, 32'h3344_1122);
        push_bus(32'h204, 4'b0011, 1'b1, 32'h3344_1122);
        push_rsp(1'b0, 32'd0); push_rsp(1'b0, 32'd0);
        issue(1'b1, 2'b00, 1'b0, 32'h1122_3344, 32'h202, 32'd0, 1'b0, 1'b0, 2, 0);
        // split half load with 3 grant-wait cycles per part
        push_bus(32'h4, 4'b1000, 1'b0, 32'd0); push_bus(32'h8, 4'b0001, 1'b0, 32'd0);
        push_rsp(1'b0, 32'hAB00_0000); push_rsp(1'b0, 32'h0000_00CD);
        issue(1'b0, 2'b01, 1'b1, 32'd0, 32'h7, 32'hFFFF_CDAB, 1'b0, 1'b0, -1, 3);
        // split word load, data taken from both parts
        push_bus(32'h0, 4'b1110, 1'b0, 32'd0); push_bus(32'h4, 4'b0001, 1'b0, 32'd0);
        push_rsp(1'b0, 32'h4433_2211); push_rsp(1'b0, 32'h8877_6655);
        issue(1'b0, 2'b00, 1'b0, 32'd0, 32'h1, 32'h5544_3322, 1'b0, 1'b0, 2, 0);
        // part 1 error on split load and split store: no second request
        push_bus(32'h100, 4'b1110, 1'b0, 32'd0); push_rsp(1'b1, 32'd0);
        issue(1'b0, 2'b00, 1'b0, 32'd0, 32'h101, 32'd0, 1'b1, 1'b0, 1, 0);
        push_bus(32'h300, 4'b1000, 1'b1, 32'h0DCA_FEF0); push_rsp(1'b1, 32'd0);
        issue(1'b1, 2'b00, 1'b0, 32'hCAFE_F00D, 32'h303, 32'd0, 1'b0, 1'b1, 1, 0);
        // part 2 error on split load
        push_bus(32'h40, 4'b1100, 1'b0, 32'd0); push_bus(32'h44, 4'b0011, 1'b0, 32'd0);
        push_rsp(1'b0, 32'h1111_1111); push_rsp(1'b1, 32'h2222_2222);
        issue(1'b0, 2'b00, 1'b0, 32'd0, 32'h42, 32'd0, 1'b1, 1'b0, 2, 0);
        // address wrap on part 2
        push_bus(32'hFFFF_FFFC, 4'b1100, 1'b1, 32'hCCDD_AABB);
        push_bus(32'h0000_0000, 4'b0011, 1'b1, 32'hCCDD_AABB);
        push_rsp(1'b0, 32'd0); push_rsp(1'b0, 32'd0);
        issue(1'b1, 2'b00, 1'b0, 32'hAABB_CCDD, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 2, 0);
        // unsigned half load at offset 2, byte store at offset 1, split half store
        push_bus(32'h108, 4'b1100, 1'b0, 32'd0); push_rsp(1'b0, 32'h8765_4321);
        issue(1'b0, 2'b01, 1'b0, 32'd0, 32'h10A, 32'h0000_8765, 1'b0, 1'b0, 1, 0);
        push_bus(32'h10, 4'b0010, 1'b1, 32'h0000_A500); push_rsp(1'b0, 32'd0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_00A5, 32'h11, 32'd0, 1'b0, 1'b0, 1, 0);
        push_bus(32'h10, 4'b1000, 1'b1, 32'hEF00_00BE);
        push_bus(32'h14, 4'b0001, 1'b1, 32'hEF00_00BE);
        push_rsp(1'b0, 32'd0); push_rsp(1'b0, 32'd0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_BEEF, 32'h13, 32'd0, 1'b0, 1'b0, 2, 0);
        // type 11 behaves as a word
        push_bus(32'h20, 4'b1111, 1'b0, 32'd0); push_rsp(1'b0, 32'h0BAD_F00D);
        issue(1'b0, 2'b11, 1'b1, 32'd0, 32'h20, 32'h0BAD_F00D, 1'b0, 1'b0, 1, 0);

        // misaligned disabled: no bus request, error response one cycle later
        wait_idle();
        lsu_we = 1'b0; lsu_type = 2'b00; adder_result = 32'h1; lsu_wdata = 32'd0;
        lsu_req0 = 1'b1;
        @(negedge clk);
        check("mis_load_cycle0", 64'({data_req0, resp_valid0}), 64'(0));
        @(posedge clk); #1; lsu_req0 = 1'b0;
        @(negedge clk);
        check("mis_load_resp", 64'({resp_valid0, load_err0, store_err0, busy0, data_req0}),
              64'(5'b11010));
        check("mis_load_rdata", 64'(lsu_rdata0), 64'(0));
        @(negedge clk);
        check("mis_load_after", 64'({resp_valid0, busy0}), 64'(0));
        @(posedge clk); #1;
        lsu_we = 1'b1; lsu_type = 2'b01; adder_result = 32'h3; lsu_req0 = 1'b1;
        @(posedge clk); #1; lsu_req0 = 1'b0;
        @(negedge clk);
        check("mis_store_resp", 64'({resp_valid0, load_err0, store_err0, busy0, data_req0}),
              64'(5'b10110));

        // reset while waiting for the response of an aligned load
        push_bus(32'h300, 4'b1111, 1'b0, 32'd0); push_rsp(1'b0, 32'h7777_7777);
        wait_idle();
        gnt_wait = 0;
        lsu_we = 1'b0; lsu_type = 2'b00; lsu_sign_ext = 1'b0; lsu_wdata = 32'd0;
        adder_result = 32'h300; lsu_req = 1'b1;
        @(posedge clk); #1; lsu_req = 1'b0;
        check("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #3;
        check("midreset_bus", 64'({data_req, data_we, data_be, data_addr}), 64'(0));
        check("midreset_rsp", 64'({lsu_rdata, resp_valid, load_err, store_err, busy}), 64'(0));
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1; stale = 1'b1;
        @(negedge clk);
        check("stale_rvalid_ignored", 64'({resp_valid, busy}), 64'(0));

        // recovery after reset
        push_bus(32'h400, 4'b1111, 1'b0, 32'd0); push_rsp(1'b0, 32'h5A5A_5A5A);
        issue(1'b0, 2'b00, 1'b0, 32'd0, 32'h400, 32'h5A5A_5A5A, 1'b0, 1'b0, 1, 0);

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'(0));
        check("bus_q_drained", 64'(bus_q.size()), 64'(0));
        check("rsp_q_drained", 64'(rsp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
